// File: rtl/tx_arbiter.sv
// tx_arbiter: decides who owns the transmitter, the host or the auto-ack
// source. A host frame waits for a quiet line. An ack frame only has to
// arrive inside a window that opens after each received frame. Every
// transmission is guarded by a watchdog and followed by a fixed dead time.
//
// Handshake: a request is a level held by its requester. The owner is told by
// a registered grant that is high from START through ACTIVE. tx_start and
// tx_abort are single-cycle registered pulses to the framer. The framer ends a
// transmission with a single-cycle tx_done. The requester drops its request on
// tx_done; a request that is still high once HOLD ends counts as a new request.
module tx_arbiter #(
   parameter int IDLE_CYCLES = 64,
   parameter int ACK_WINDOW  = 1024,
   parameter int HOLDOFF     = 8,
   parameter int TX_TIMEOUT  = 65535
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       line_idle,
   input  logic       no_clock,
   input  logic       rx_frame_done,
   input  logic       req_host,
   input  logic       req_ack,
   input  logic       tx_done,
   output logic       grant_host,
   output logic       grant_ack,
   output logic       tx_start,
   output logic       tx_abort,
   output logic       ack_dropped,
   output logic       busy,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      ACTIVE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam logic [15:0] IDLE_MAX  = 16'(IDLE_CYCLES);
   localparam logic [10:0] WIN_LOAD  = 11'(ACK_WINDOW);
   localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);
   localparam logic [15:0] WD_LIMIT  = 16'(TX_TIMEOUT);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] idle_cnt;
   logic [10:0] win_cnt;
   logic [15:0] wd_cnt;
   logic [15:0] wd_nxt;
   logic [15:0] hold_cnt;
   logic [15:0] hold_nxt;
   logic        drop_seen;

   logic        grant_host_nxt;
   logic        grant_ack_nxt;
   logic        tx_start_nxt;
   logic        tx_abort_nxt;
   logic        ack_dropped_nxt;
   logic        busy_nxt;

   logic        ack_ok;
   logic        idle_full;

   assign ack_ok    = (win_cnt != 11'd0);
   assign idle_full = (idle_cnt == IDLE_MAX);
   assign fsm_state = state;

   // Quiet-line counter: counts clean idle cycles, saturates, and restarts
   // whenever the line is busy, the clock is lost, or we are transmitting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= 16'd0;
      end else if ((state == START) || (state == ACTIVE) || !line_idle || no_clock) begin
         idle_cnt <= 16'd0;
      end else if (!idle_full) begin
         idle_cnt <= idle_cnt + 16'd1;
      end
   end

   // Ack window: reopened by every received frame, drains to zero otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_cnt <= 11'd0;
      end else if (rx_frame_done) begin
         win_cnt <= WIN_LOAD;
      end else if (ack_ok) begin
         win_cnt <= win_cnt - 11'd1;
      end
   end

   // Remembers that the current ack request was already reported as dropped,
   // so a held request produces only one ack_dropped pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         drop_seen <= 1'b0;
      end else if (!req_ack) begin
         drop_seen <= 1'b0;
      end else if (ack_dropped_nxt) begin
         drop_seen <= 1'b1;
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nxt       = state;
      wd_nxt          = wd_cnt;
      hold_nxt        = hold_cnt;
      grant_host_nxt  = grant_host;
      grant_ack_nxt   = grant_ack;
      tx_start_nxt    = 1'b0;
      tx_abort_nxt    = 1'b0;
      ack_dropped_nxt = 1'b0;

      case (state)
         IDLE: begin
            grant_host_nxt = 1'b0;
            grant_ack_nxt  = 1'b0;
            if (req_ack && !ack_ok && !drop_seen) begin
               ack_dropped_nxt = 1'b1;
            end
            // Ack has priority and ignores the quiet-line counter; nothing
            // is granted while the network clock is missing.
            if (!no_clock) begin
               if (req_ack && ack_ok) begin
                  state_nxt     = START;
                  grant_ack_nxt = 1'b1;
                  tx_start_nxt  = 1'b1;
               end else if (req_host && idle_full) begin
                  state_nxt      = START;
                  grant_host_nxt = 1'b1;
                  tx_start_nxt   = 1'b1;
               end
            end
         end
         START: begin
            state_nxt = ACTIVE;
            wd_nxt    = 16'd0;
         end
         ACTIVE: begin
            // A normal end beats a coinciding abort condition.
            if (tx_done) begin
               state_nxt      = HOLD;
               hold_nxt       = 16'd0;
               grant_host_nxt = 1'b0;
               grant_ack_nxt  = 1'b0;
            end else if (no_clock || (wd_cnt == WD_LIMIT)) begin
               state_nxt      = HOLD;
               hold_nxt       = 16'd0;
               grant_host_nxt = 1'b0;
               grant_ack_nxt  = 1'b0;
               tx_abort_nxt   = 1'b1;
            end else begin
               wd_nxt = wd_cnt + 16'd1;
            end
         end
         HOLD: begin
            grant_host_nxt = 1'b0;
            grant_ack_nxt  = 1'b0;
            if (hold_cnt == HOLD_LAST) begin
               state_nxt = IDLE;
            end else begin
               hold_nxt = hold_cnt + 16'd1;
            end
         end
         default: begin
            state_nxt      = IDLE;
            grant_host_nxt = 1'b0;
            grant_ack_nxt  = 1'b0;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // State register, watchdog, dead-time counter and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         wd_cnt      <= 16'd0;
         hold_cnt    <= 16'd0;
         grant_host  <= 1'b0;
         grant_ack   <= 1'b0;
         tx_start    <= 1'b0;
         tx_abort    <= 1'b0;
         ack_dropped <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         wd_cnt      <= wd_nxt;
         hold_cnt    <= hold_nxt;
         grant_host  <= grant_host_nxt;
         grant_ack   <= grant_ack_nxt;
         tx_start    <= tx_start_nxt;
         tx_abort    <= tx_abort_nxt;
         ack_dropped <= ack_dropped_nxt;
         busy        <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed scenarios for the main arbitration cases, followed
// by a randomized run. A cycle-level reference model of the arbitration rules
// predicts the six control outputs for every clock.
module tb_tx_arbiter;

   localparam int IDLE_CYCLES = 64;
   localparam int ACK_WINDOW  = 1024;
   localparam int HOLDOFF     = 8;
   localparam int TX_TIMEOUT  = 100;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       reset_n;
   logic       line_idle;
   logic       no_clock;
   logic       rx_frame_done;
   logic       req_host;
   logic       req_ack;
   logic       tx_done;
   logic       grant_host;
   logic       grant_ack;
   logic       tx_start;
   logic       tx_abort;
   logic       ack_dropped;
   logic       busy;
   logic [1:0] fsm_state;

   always #5 clk = ~clk;

   tx_arbiter #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .ACK_WINDOW  (ACK_WINDOW),
      .HOLDOFF     (HOLDOFF),
      .TX_TIMEOUT  (TX_TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .line_idle     (line_idle),
      .no_clock      (no_clock),
      .rx_frame_done (rx_frame_done),
      .req_host      (req_host),
      .req_ack       (req_ack),
      .tx_done       (tx_done),
      .grant_host    (grant_host),
      .grant_ack     (grant_ack),
      .tx_start      (tx_start),
      .tx_abort      (tx_abort),
      .ack_dropped   (ack_dropped),
      .busy          (busy),
      .fsm_state     (fsm_state)
   );

   // ---------------- scoreboard ----------------
   int         total = 0;
   int         bad   = 0;
   logic [5:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Owner of the transmitter: 0 none, 1 host, 2 ack. m_starting marks the
   // single start cycle, m_age is the number of transmit cycles already
   // spent, m_hold the dead cycles still to serve.
   int m_owner;
   int m_hold;
   int m_age;
   int m_idle;
   int m_win;
   bit m_starting;
   bit m_drop_used;
   bit e_start;
   bit e_abort;
   bit e_drop;

   function automatic logic [5:0] model_vec();
      return {m_owner == 1, m_owner == 2, e_start, e_abort, e_drop, (m_owner != 0) || (m_hold != 0)};
   endfunction

   function automatic logic [5:0] obs_vec();
      return {grant_host, grant_ack, tx_start, tx_abort, ack_dropped, busy};
   endfunction

   task automatic model_reset();
      m_owner = 0; m_hold = 0; m_age = 0; m_idle = 0; m_win = 0;
      m_starting = 0; m_drop_used = 0;
      e_start = 0; e_abort = 0; e_drop = 0;
   endtask

   // Apply one clock of the arbitration rules to the inputs now on the pins.
   task automatic model_edge();
      int n_idle;
      int n_win;
      bit sending;
      bit free;
      sending = (m_owner != 0);
      free    = !sending && (m_hold == 0);
      e_start = 0; e_abort = 0; e_drop = 0;

      if (!sending && line_idle && !no_clock) n_idle = (m_idle < IDLE_CYCLES) ? m_idle + 1 : m_idle;
      else n_idle = 0;
      if (rx_frame_done) n_win = ACK_WINDOW;
      else n_win = (m_win > 0) ? m_win - 1 : 0;

      if (free) begin
         if (req_ack && (m_win == 0) && !m_drop_used) e_drop = 1;
         if (!no_clock && req_ack && (m_win > 0)) begin
            m_owner = 2; m_starting = 1; e_start = 1;
         end else if (!no_clock && req_host && (m_idle == IDLE_CYCLES)) begin
            m_owner = 1; m_starting = 1; e_start = 1;
         end
      end else if (m_starting) begin
         m_starting = 0;
         m_age = 0;
      end else if (sending) begin
         if (tx_done || no_clock || (m_age == TX_TIMEOUT)) begin
            e_abort = !tx_done;
            m_owner = 0;
            m_hold  = HOLDOFF;
         end else begin
            m_age++;
         end
      end else begin
         m_hold--;
      end

      m_drop_used = req_ack ? (m_drop_used | e_drop) : 1'b0;
      m_idle = n_idle;
      m_win  = n_win;
   endtask

   // ---------------- driver tasks ----------------
   // One clock: predict, advance, sample 1 ns after the edge, compare.
   task automatic tick();
      if (reset_n) begin
         model_edge();
         exp_q.push_back(model_vec());
      end
      @(posedge clk);
      #1;
      if (!reset_n) begin
         model_reset();
         exp_q.push_back(6'b0);
      end
      check_eq("outputs", 32'(obs_vec()), 32'(exp_q.pop_front()));
      rx_frame_done = 1'b0;
      tx_done       = 1'b0;
   endtask

   task automatic wait_grant(input string tag, input int limit, output int n);
      n = 0;
      while (!(grant_host || grant_ack) && (n < limit)) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(grant_host || grant_ack), 1);
   endtask

   // Called in HOLD's first cycle: grants must stay low for the full dead time.
   task automatic hold_check();
      int n;
      n = 0;
      while (busy && (n < 4 * HOLDOFF)) begin
         check_eq("hold_grants", 32'({grant_host, grant_ack}), 0);
         n++;
         tick();
      end
      check_eq("hold_len", n, HOLDOFF);
   endtask

   // Called in the START cycle: let the framer run, end with tx_done, then
   // check the dead time.
   task automatic finish_tx(input int active_cycles);
      tick();
      repeat (active_cycles - 1) tick();
      tx_done = 1'b1;
      if (m_owner == 1) req_host = 1'b0;
      else req_ack = 1'b0;
      tick();
      hold_check();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int cnt;
      int seen;

      reset_n = 1'b0; line_idle = 1'b0; no_clock = 1'b0; rx_frame_done = 1'b0;
      req_host = 1'b0; req_ack = 1'b0; tx_done = 1'b0;
      model_reset();
      tick();
      tick();
      check_eq("reset_outs", 32'(obs_vec()), 0);
      check_eq("reset_state", 32'(fsm_state), 0);
      reset_n = 1'b1;

      // Host needs a full quiet period before it is granted.
      line_idle = 1'b1;
      repeat (IDLE_CYCLES - 1) tick();
      req_host = 1'b1;
      n = 0;
      while (!grant_host && (n < 10)) begin
         tick();
         n++;
      end
      check_eq("host_grant_lat", n, 2);
      check_eq("host_tx_start", 32'(tx_start), 1);
      finish_tx(5);

      // Ack inside the window is granted even on a busy line.
      line_idle = 1'b0;
      rx_frame_done = 1'b1;
      tick();
      repeat (499) tick();
      req_ack = 1'b1;
      wait_grant("ack_wait", 5, n);
      check_eq("ack_grant_lat", n, 1);
      check_eq("ack_grant", 32'({grant_ack, grant_host, tx_start}), 32'b101);
      finish_tx(3);

      // Ack outside the window: one ack_dropped pulse, no grant, while held.
      rx_frame_done = 1'b1;
      tick();
      repeat (1100) tick();
      req_ack = 1'b1;
      cnt = 0;
      seen = 0;
      repeat (30) begin
         tick();
         if (ack_dropped) cnt++;
         if (grant_ack) seen++;
      end
      check_eq("ack_drop_pulses", cnt, 1);
      check_eq("ack_drop_nogrant", seen, 0);
      req_ack = 1'b0;
      tick();

      // Simultaneous eligible requests: ack first, host after a new quiet period.
      line_idle = 1'b1;
      repeat (70) tick();
      rx_frame_done = 1'b1;
      tick();
      req_host = 1'b1;
      req_ack  = 1'b1;
      tick();
      check_eq("both_ack_wins", 32'({grant_ack, grant_host}), 32'b10);
      finish_tx(3);
      check_eq("host_still_req", 32'(req_host), 1);
      n = 0;
      while (!grant_host && (n < 200)) begin
         tick();
         n++;
      end
      check_eq("host_after_hold", n, IDLE_CYCLES - HOLDOFF + 1);
      finish_tx(4);

      // Watchdog expiry, then tx_done landing exactly in the expiry cycle.
      req_host = 1'b1;
      wait_grant("wd_grant", 200, n);
      tick();
      n = 0;
      while (!tx_abort && (n < 3 * TX_TIMEOUT)) begin
         tick();
         n++;
      end
      check_eq("timeout_cycles", n, TX_TIMEOUT + 1);
      req_host = 1'b0;
      hold_check();
      req_host = 1'b1;
      wait_grant("wd2_grant", 200, n);
      tick();
      repeat (TX_TIMEOUT) tick();
      tx_done  = 1'b1;
      req_host = 1'b0;
      tick();
      check_eq("done_at_timeout", 32'({tx_abort, busy, grant_host}), 32'b010);
      hold_check();

      // Clock loss while transmitting aborts the frame.
      req_host = 1'b1;
      wait_grant("nc_grant", 200, n);
      tick();
      repeat (3) tick();
      no_clock = 1'b1;
      tick();
      check_eq("noclk_abort", 32'({tx_abort, grant_host}), 32'b10);
      no_clock = 1'b0;
      req_host = 1'b0;
      hold_check();

      // Reset in the middle of a transmission clears everything at once.
      req_host = 1'b1;
      wait_grant("rst_grant", 200, n);
      tick();
      repeat (3) tick();
      #3;
      reset_n = 1'b0;
      #1;
      check_eq("async_reset_outs", 32'(obs_vec()), 0);
      model_reset();
      req_host = 1'b0; line_idle = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;

      // After reset the ack window is closed and the quiet period restarts.
      req_ack = 1'b1;
      cnt = 0;
      seen = 0;
      repeat (5) begin
         tick();
         if (ack_dropped) cnt++;
         if (grant_ack) seen++;
      end
      check_eq("post_reset_drop", cnt, 1);
      check_eq("post_reset_nogrant", seen, 0);
      req_ack = 1'b0;
      tick();
      line_idle = 1'b1;
      req_host = 1'b1;
      n = 0;
      while (!grant_host && (n < 200)) begin
         tick();
         n++;
      end
      check_eq("post_reset_host_lat", n, IDLE_CYCLES + 1);
      finish_tx(2);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 79) == 0) line_idle = ~line_idle;
         if (no_clock) begin
            if ($urandom_range(0, 3) == 0) no_clock = 1'b0;
         end else if ($urandom_range(0, 299) == 0) begin
            no_clock = 1'b1;
         end
         rx_frame_done = ($urandom_range(0, 399) == 0);
         if (!req_host && ($urandom_range(0, 49) == 0)) req_host = 1'b1;
         if (!req_ack && ($urandom_range(0, 199) == 0)) req_ack = 1'b1;
         if (req_ack && (m_owner != 2) && (m_win == 0) && ($urandom_range(0, 19) == 0)) req_ack = 1'b0;
         if ((m_owner != 0) && !m_starting && ($urandom_range(0, 59) == 0)) begin
            tx_done = 1'b1;
            if (m_owner == 1) req_host = 1'b0;
            else req_ack = 1'b0;
         end
         tick();
      end

      req_host = 1'b0; req_ack = 1'b0; no_clock = 1'b0;
      repeat (TX_TIMEOUT + 2 * HOLDOFF + 4) tick();
      check_eq("final_idle", 32'({busy, grant_host, grant_ack}), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
